ram_lvt_nrmw: RTL
=================

// Module: ram_lvt_nrmw
// PURPOSE
// - Multi-port RAM, nRPORTS read x nWPORTS write, single clock; successor to the replicated nR1W RAM wrapper.
// - Storage is nWPORTS*nRPORTS 1W1R bank replicas plus a per-byte-lane Live Value Table (LVT).
// - Adds a post-reset zero-clear sequencer, registered read valids and optional write-to-read bypass.
// - Serves register-file and ICCM/DCCM-side structures in the core needing >1 write port.
// PARAMETERS
// - DATA_WIDTH  32   word width; multiple of 8
// - NUM_WMASKS  4    byte lanes = DATA_WIDTH/8
// - MEMD        256  words; need not be a power of 2
// - ADDR_WIDTH  8    address bits; 2**ADDR_WIDTH >= MEMD
// - nRPORTS     2    read ports, >=1
// - nWPORTS     2    write ports, >=1
// - IZERO       1    1: zero-clear all words after reset; 0: contents undefined, ready at once
// PORTS
// - clk     in   1                     clock, all state on rising edge
// - rst_l   in   1                     reset, asynchronous, active low
// - ready   out  1                     1 = accepting reads/writes; 0 during clear
// - we      in   nWPORTS               write enable per write port
// - wmask   in   nWPORTS*NUM_WMASKS    byte-lane enables, port w at [w*NUM_WMASKS +: NUM_WMASKS]
// - waddr   in   nWPORTS*ADDR_WIDTH    write address, packed per port
// - wdata   in   nWPORTS*DATA_WIDTH    write data, packed per port
// - re      in   nRPORTS               read enable per read port
// - raddr   in   nRPORTS*ADDR_WIDTH    read address, packed per port
// - rdata   out  nRPORTS*DATA_WIDTH    read data, packed per port
// - rvalid  out  nRPORTS               rdata valid, one cycle after accepted re
// BEHAVIOUR
// - Reset (async assert, sync-released use): rdata=0, rvalid=0, LVT=0, clear counter=0;
//   ready=0 and FSM=CLEAR if IZERO else ready=1 and FSM=READY.
// - FSM CLEAR: counter 0..MEMD-1, one word/cycle, writes 0 to all lanes of all banks, LVT entry=0;
//   at counter==MEMD-1 -> READY next cycle (ready=1). Clear takes exactly MEMD cycles.
//   we/re ignored while ready=0; rvalid stays 0. rst_l low mid-clear restarts from counter 0.
// - FSM READY: terminal; only reset leaves it.
// - Write (ready=1, we[w]=1): for each lane b with wmask bit set, bank[w][r] lane b <= wdata lane b
//   for every r, LVT[waddr][b] <= w. wmask=0 is a no-op.
// - Write collision (two ports, same address, same lane, same cycle): highest port index wins via LVT.
// - Read (ready=1, re[r]=1): latency 1; rdata lane b = bank[LVT[raddr][b]][r] lane b; rvalid[r]=1
//   for exactly that cycle. When rvalid[r]=0, rdata[r] holds its last value.
// - Address >= MEMD: write dropped (no bank/LVT change); read returns 0 with rvalid=1.
// - Read-during-write same address: see CONFIGURATION.
// CONFIGURATION
// - RAM_WR_BYPASS_EN defined: write-first; read of an address written in the same cycle returns the
//   new data on written lanes (collision winner = highest port) and old data on unmasked lanes.
// - Not defined: read-first; same-cycle read returns pre-write contents on all lanes.
// STRUCTURE
// - Package ram_lvt_pkg: lvt_idx_t (clog2(nWPORTS) bits, min 1), state enum {CLEAR, READY},
//   lane-width constant 8, pack/unpack helper functions.
// - Sub-module ram_bank_1w1r: one 1W1R bank, synchronous read, per-lane write enable; instantiated
//   nWPORTS*nRPORTS times in a generate loop. LVT, FSM, bypass and output regs live in the top.
// TESTING
// - Reset, IZERO=1, MEMD=256 -> ready=0 for 256 cycles then 1; read addr 0x00 and 0xFF -> 0x00000000.
// - W0 writes 0xDEADBEEF @0x10, next cycle R1 reads 0x10 -> rvalid 1 cycle later, rdata=0xDEADBEEF.
// - W0 0x11111111 and W1 0x22222222 both @0x20 same cycle -> read 0x20 returns 0x22222222.
// - W0 0xAAAAAAAA full @0x30, then W1 0x000000BB wmask=0001 @0x30 -> read returns 0xAAAAAABB.
// - Same cycle W0 0x12345678 @0x40 (held 0xCAFEF00D) and R0 read 0x40 -> 0x12345678 with
//   RAM_WR_BYPASS_EN, 0xCAFEF00D without.
// - rst_l low at clear counter 100 -> ready=0, full MEMD-cycle clear repeats; re during clear -> rvalid=0.

Source files
------------

// File: rtl/ram_lvt_pkg.sv
// Shared types and helpers for the LVT-based multi-port RAM.
package ram_lvt_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned DEF_WPORTS = 2;

    typedef enum logic [0:0] {CLEAR, READY} state_e;

    // Bits needed to name a write port in the LVT; never less than one.
    function automatic int unsigned lvt_width(input int unsigned nports);
        return (nports > 1) ? $clog2(nports) : 1;
    endfunction

    typedef logic [lvt_width(DEF_WPORTS)-1:0] lvt_idx_t;

    // Bit offset of byte lane 'lane' of packed element 'idx' in a flattened port bus.
    function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned lane,
                                             input int unsigned lanes);
        return (idx * lanes + lane) * LANE_W;
    endfunction

endpackage

// File: rtl/ram_bank_1w1r.sv
// One 1W1R storage replica: byte-lane write enables, registered synchronous read.
module ram_bank_1w1r
    import ram_lvt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned MEMD       = 256,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  we,
    input  logic [NUM_WMASKS-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEMD];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                if (wmask[b]) begin
                    mem[waddr][b*LANE_W +: LANE_W] <= wdata[b*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read-first: a same-edge write is not visible here.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_lvt_nrmw.sv
// nR x nW RAM built from 1W1R replicas steered by a per-byte-lane Live Value Table.
// Define RAM_WR_BYPASS_EN for write-first reads; default build is read-first.
module ram_lvt_nrmw
    import ram_lvt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned MEMD       = 256,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned nRPORTS    = 2,
    parameter int unsigned nWPORTS    = 2,
    parameter int unsigned IZERO      = 1
) (
    input  logic                             clk,
    input  logic                             rst_l,
    output logic                             ready,
    input  logic [nWPORTS-1:0]               we,
    input  logic [nWPORTS*NUM_WMASKS-1:0]    wmask,
    input  logic [nWPORTS*ADDR_WIDTH-1:0]    waddr,
    input  logic [nWPORTS*DATA_WIDTH-1:0]    wdata,
    input  logic [nRPORTS-1:0]               re,
    input  logic [nRPORTS*ADDR_WIDTH-1:0]    raddr,
    output logic [nRPORTS*DATA_WIDTH-1:0]    rdata,
    output logic [nRPORTS-1:0]               rvalid
);

    localparam int unsigned LVT_W = lvt_width(nWPORTS);
    localparam logic [ADDR_WIDTH:0]   MEMD_X    = (ADDR_WIDTH+1)'(MEMD);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMD - 1);

    state_e                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= (IZERO != 0) ? CLEAR : READY;
            ready   <= (IZERO == 0);
            clr_cnt <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY:   ;
                default: state <= READY;
            endcase
        end
    end

    logic [nWPORTS-1:0] wr_ok;
    logic [nRPORTS-1:0] rd_ok;
    logic [nRPORTS-1:0] rd_in;

    always_comb begin
        wr_ok = '0;
        rd_ok = '0;
        rd_in = '0;
        for (int unsigned w = 0; w < nWPORTS; w++) begin
            wr_ok[w] = ready & we[w] & ({1'b0, waddr[w*ADDR_WIDTH +: ADDR_WIDTH]} < MEMD_X);
        end
        for (int unsigned r = 0; r < nRPORTS; r++) begin
            rd_ok[r] = ready & re[r];
            rd_in[r] = ({1'b0, raddr[r*ADDR_WIDTH +: ADDR_WIDTH]} < MEMD_X);
        end
    end

    // While clearing, every bank is driven with a full-lane zero write at the counter address.
    logic [nWPORTS-1:0]    bk_we;
    logic [NUM_WMASKS-1:0] bk_mask  [nWPORTS];
    logic [ADDR_WIDTH-1:0] bk_addr  [nWPORTS];
    logic [DATA_WIDTH-1:0] bk_wdata [nWPORTS];
    logic [DATA_WIDTH-1:0] bk_rdata [nWPORTS][nRPORTS];

    always_comb begin
        bk_we = '0;
        for (int unsigned w = 0; w < nWPORTS; w++) begin
            bk_we[w]    = !ready | wr_ok[w];
            bk_mask[w]  = ready ? wmask[w*NUM_WMASKS +: NUM_WMASKS] : '1;
            bk_addr[w]  = ready ? waddr[w*ADDR_WIDTH +: ADDR_WIDTH] : clr_cnt;
            bk_wdata[w] = ready ? wdata[w*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    for (genvar gw = 0; gw < nWPORTS; gw++) begin : g_wport
        for (genvar gr = 0; gr < nRPORTS; gr++) begin : g_rport
            ram_bank_1w1r #(
                .DATA_WIDTH (DATA_WIDTH),
                .NUM_WMASKS (NUM_WMASKS),
                .MEMD       (MEMD),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_bank (
                .clk   (clk),
                .rst_l (rst_l),
                .we    (bk_we[gw]),
                .wmask (bk_mask[gw]),
                .waddr (bk_addr[gw]),
                .wdata (bk_wdata[gw]),
                .re    (rd_ok[gr] & rd_in[gr]),
                .raddr (raddr[gr*ADDR_WIDTH +: ADDR_WIDTH]),
                .rdata (bk_rdata[gw][gr])
            );
        end
    end

    logic [LVT_W-1:0] lvt [MEMD][NUM_WMASKS];

    // Ascending port order: the highest-numbered writer of a lane owns it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int unsigned i = 0; i < MEMD; i++) begin
                for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                    lvt[i][b] <= '0;
                end
            end
        end else if (!ready) begin
            for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                lvt[clr_cnt][b] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < nWPORTS; w++) begin
                for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                    if (wr_ok[w] && wmask[w*NUM_WMASKS + b]) begin
                        lvt[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]][b] <= LVT_W'(w);
                    end
                end
            end
        end
    end

    logic [NUM_WMASKS-1:0] byp_hit_d  [nRPORTS];
    logic [DATA_WIDTH-1:0] byp_data_d [nRPORTS];

    always_comb begin
        for (int unsigned r = 0; r < nRPORTS; r++) begin
            byp_hit_d[r]  = '0;
            byp_data_d[r] = '0;
`ifdef RAM_WR_BYPASS_EN
            for (int unsigned w = 0; w < nWPORTS; w++) begin
                for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                    if (wr_ok[w] && wmask[w*NUM_WMASKS + b] &&
                        waddr[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
                        byp_hit_d[r][b] = 1'b1;
                        byp_data_d[r][b*LANE_W +: LANE_W] =
                            wdata[lane_lsb(w, b, NUM_WMASKS) +: LANE_W];
                    end
                end
            end
`endif
        end
    end

    logic [LVT_W-1:0]      sel_q      [nRPORTS][NUM_WMASKS];
    logic [nRPORTS-1:0]    oor_q;
    logic [NUM_WMASKS-1:0] byp_hit_q  [nRPORTS];
    logic [DATA_WIDTH-1:0] byp_data_q [nRPORTS];

    // Selection state only moves on an accepted read, so rdata holds between reads.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rvalid <= '0;
            oor_q  <= '0;
            for (int unsigned r = 0; r < nRPORTS; r++) begin
                byp_hit_q[r]  <= '0;
                byp_data_q[r] <= '0;
                for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                    sel_q[r][b] <= '0;
                end
            end
        end else begin
            rvalid <= rd_ok;
            for (int unsigned r = 0; r < nRPORTS; r++) begin
                if (rd_ok[r]) begin
                    oor_q[r]      <= !rd_in[r];
                    byp_hit_q[r]  <= byp_hit_d[r];
                    byp_data_q[r] <= byp_data_d[r];
                    for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                        sel_q[r][b] <= rd_in[r] ? lvt[raddr[r*ADDR_WIDTH +: ADDR_WIDTH]][b] : '0;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned r = 0; r < nRPORTS; r++) begin
            for (int unsigned b = 0; b < NUM_WMASKS; b++) begin
                if (oor_q[r]) begin
                    rdata[lane_lsb(r, b, NUM_WMASKS) +: LANE_W] = '0;
                end else if (byp_hit_q[r][b]) begin
                    rdata[lane_lsb(r, b, NUM_WMASKS) +: LANE_W] =
                        byp_data_q[r][b*LANE_W +: LANE_W];
                end else begin
                    rdata[lane_lsb(r, b, NUM_WMASKS) +: LANE_W] =
                        bk_rdata[sel_q[r][b]][r][b*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule
